// File: rtl/video_scale_int_pkg.sv
// video_scale_pkg: shared types and constants for the integer-scaling
// aspect calculator (width snapping enabled by VIDEO_SCALE_INT_H_EN).
package video_scale_pkg;

  localparam int SZ_W    = 12;
  localparam int DVD_W   = 24;
  localparam int OUT_W   = 13;
  localparam int DIV_LAT = 25;

  typedef logic [SZ_W-1:0]  size_t;
  typedef logic [DVD_W-1:0] dvd_t;
  typedef logic [OUT_W-1:0] ar_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV_V,
    S_MUL_V,
    S_DIV_A,
    S_DIV_H,
    S_DONE
  } state_t;

  localparam logic [1:0] SC_PASS  = 2'd0;
  localparam logic [1:0] SC_VERT  = 2'd1;
  localparam logic [1:0] SC_BOTH  = 2'd2;
  localparam logic [1:0] SC_VERT3 = 2'd3;

  function automatic size_t clip_sz(input dvd_t v, input size_t lim);
    return (v > dvd_t'(lim)) ? lim : v[SZ_W-1:0];
  endfunction

endpackage

// File: rtl/video_scale_int_if.sv
// video_scale_int_if: absolute-size aspect words and busy flag
// handed from the calculator to the scaler.
interface video_scale_int_if;
  import video_scale_pkg::*;

  ar_t  VIDEO_ARX;
  ar_t  VIDEO_ARY;
  logic BUSY;

  modport master (
    output VIDEO_ARX,
    output VIDEO_ARY,
    output BUSY
  );

  modport slave (
    input VIDEO_ARX,
    input VIDEO_ARY,
    input BUSY
  );

endinterface

// File: rtl/video_scale_int_div.sv
// video_div_seq: restoring divider, 24-bit dividend / 12-bit divisor,
// one quotient bit per cycle, done pulse with the final quotient.
module video_div_seq
  import video_scale_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  start,
  input  dvd_t  dividend,
  input  size_t divisor,
  output logic  done,
  output dvd_t  quo
);

  logic          busy;
  logic [4:0]    cnt;
  size_t         rem;
  logic [SZ_W:0] trial;
  logic [SZ_W:0] diff;
  logic          ge;

  always_comb begin
    trial = {rem, quo[DVD_W-1]};
    diff  = trial - {1'b0, divisor};
    ge    = (trial >= {1'b0, divisor});
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          cnt  <= 5'(DIV_LAT - 1);
          rem  <= '0;
          quo  <= dividend;
        end
      end else begin
        rem <= ge ? diff[SZ_W-1:0] : trial[SZ_W-1:0];
        quo <= {quo[DVD_W-2:0], ge};
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/video_scale_int.sv
// video_scale_int: measures cropped frame size and derives integer output
// dimensions; define VIDEO_SCALE_INT_H_EN to snap width to hsize multiples.
module video_scale_int
  import video_scale_pkg::*;
(
  input  logic              CLK_VIDEO,
  input  logic              RESET,
  input  logic              CE_PIXEL,
  input  logic              VGA_VS,
  input  logic              VGA_DE,
  input  size_t             ARX,
  input  size_t             ARY,
  input  size_t             HDMI_WIDTH,
  input  size_t             HDMI_HEIGHT,
  input  logic [1:0]        SCALE,
  video_scale_int_if.master ar
);

  logic   vs_q, de_q, evt, de_fall;
  size_t  vcnt, vsize;
  size_t  arx_l, ary_l, hw_l, hh_l;
  logic   bad, bad_l, use_h;
  state_t state_q, state_d;
  logic   kick_q, kick_h;
  logic   div_done;
  dvd_t   div_quo, dvd;
  size_t  dvs;
  size_t  vq, oheight, wa, ow_sel;
  ar_t    arx_q, ary_q;

  assign evt     = CE_PIXEL & VGA_VS & ~vs_q;
  assign de_fall = CE_PIXEL & ~VGA_DE & de_q;

`ifdef VIDEO_SCALE_INT_H_EN
  size_t      hcnt, hsize_run, hsize, owidth, hq;
  logic [1:0] scale_l;
  dvd_t       prod_h;

  assign use_h  = (scale_l == SC_BOTH);
  assign ow_sel = use_h ? owidth : wa;

  always_comb begin
    hq     = (div_quo[SZ_W-1:0] == '0) ? size_t'(1) : div_quo[SZ_W-1:0];
    prod_h = dvd_t'(hq) * dvd_t'(hsize);
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      hcnt      <= '0;
      hsize_run <= '0;
      hsize     <= '0;
      scale_l   <= SC_PASS;
      owidth    <= '0;
    end else begin
      if (CE_PIXEL && VGA_DE) begin
        if (hcnt != '1) hcnt <= hcnt + size_t'(1);
      end else if (de_fall) begin
        hsize_run <= hcnt;
        hcnt      <= '0;
      end
      if (evt) begin
        hsize   <= hsize_run;
        scale_l <= SCALE;
      end
      if (state_q == S_DIV_H && div_done)
        owidth <= clip_sz(prod_h, hw_l);
    end
  end
`else
  assign use_h  = 1'b0;
  assign ow_sel = wa;
`endif

  // vq == 0 is known up front: it happens exactly when height < lines
  always_comb begin
    bad = (vcnt == '0) || (ARY == '0) || ARX[SZ_W-1] ||
          ARY[SZ_W-1] || (HDMI_HEIGHT < vcnt);
`ifdef VIDEO_SCALE_INT_H_EN
    if (SCALE == SC_BOTH && hsize_run == '0) bad = 1'b1;
`endif
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      vcnt  <= '0;
      vsize <= '0;
      arx_l <= '0;
      ary_l <= '0;
      hw_l  <= '0;
      hh_l  <= '0;
      bad_l <= 1'b0;
    end else begin
      if (CE_PIXEL) begin
        vs_q <= VGA_VS;
        de_q <= VGA_DE;
      end
      if (evt) begin
        vcnt  <= '0;
        vsize <= vcnt;
        arx_l <= ARX;
        ary_l <= ARY;
        hw_l  <= HDMI_WIDTH;
        hh_l  <= HDMI_HEIGHT;
        bad_l <= bad;
      end else if (de_fall && vcnt != '1) begin
        vcnt <= vcnt + size_t'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_DIV_V: if (div_done) state_d = S_MUL_V;
      S_MUL_V: state_d = S_DIV_A;
      S_DIV_A: if (div_done) state_d = use_h ? S_DIV_H : S_DONE;
`ifdef VIDEO_SCALE_INT_H_EN
      S_DIV_H: if (div_done) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (evt) begin
      if (SCALE == SC_PASS) state_d = S_IDLE;
      else if (bad)         state_d = S_DONE;
      else                  state_d = S_DIV_V;
    end
  end

  // kick_h delays the width division one cycle behind the DIV_A result
  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      state_q <= S_IDLE;
      kick_q  <= 1'b0;
      kick_h  <= 1'b0;
    end else begin
      state_q <= state_d;
      kick_h  <= !evt && use_h && (state_q == S_DIV_A) && div_done;
      kick_q  <= evt ? (state_d == S_DIV_V)
                     : ((state_q == S_MUL_V) || kick_h);
    end
  end

  always_comb begin
    dvd = dvd_t'(hh_l);
    dvs = vsize;
    unique case (1'b1)
      (state_q == S_DIV_A): begin
        dvd = dvd_t'(oheight) * dvd_t'(arx_l);
        dvs = ary_l;
      end
`ifdef VIDEO_SCALE_INT_H_EN
      (state_q == S_DIV_H): begin
        dvd = dvd_t'(wa);
        dvs = hsize;
      end
`endif
      default: ;
    endcase
  end

  video_div_seq u_div (
    .clk      (CLK_VIDEO),
    .rst      (RESET),
    .clr      (evt),
    .start    (kick_q),
    .dividend (dvd),
    .divisor  (dvs),
    .done     (div_done),
    .quo      (div_quo)
  );

  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      vq      <= '0;
      oheight <= '0;
      wa      <= '0;
    end else begin
      if (state_q == S_DIV_V && div_done) vq <= div_quo[SZ_W-1:0];
      if (state_q == S_MUL_V) oheight <= vq * vsize;
      if (state_q == S_DIV_A && div_done) wa <= clip_sz(div_quo, hw_l);
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      arx_q <= '0;
      ary_q <= '0;
    end else if (state_q == S_DONE && !evt) begin
      if (bad_l) begin
        arx_q <= {1'b0, arx_l};
        ary_q <= {1'b0, ary_l};
      end else begin
        arx_q <= {1'b1, ow_sel};
        ary_q <= {1'b1, oheight};
      end
    end else if (state_q == S_IDLE && SCALE == SC_PASS) begin
      arx_q <= {1'b0, ARX};
      ary_q <= {1'b0, ARY};
    end
  end

  assign ar.VIDEO_ARX = arx_q;
  assign ar.VIDEO_ARY = ary_q;
  assign ar.BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_video_scale_int.sv
// tb_video_scale_int: directed and randomized frames checked against an
// arithmetic model of the aspect calculation.
`timescale 1ns/1ps
module tb_video_scale_int;

`ifdef VIDEO_SCALE_INT_H_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ce, vs, de;
  logic [11:0] arx, ary, hw, hh;
  logic [1:0]  scale;

  int          checks   = 0;
  int          failures = 0;
  int          last_w   = 0;
  logic [12:0] cur_x, cur_y, exp_x, exp_y;
  int          exp_lat;

  video_scale_int_if ar_if ();

  video_scale_int dut (
    .CLK_VIDEO   (clk),
    .RESET       (rst),
    .CE_PIXEL    (ce),
    .VGA_VS      (vs),
    .VGA_DE      (de),
    .ARX         (arx),
    .ARY         (ary),
    .HDMI_WIDTH  (hw),
    .HDMI_HEIGHT (hh),
    .SCALE       (scale),
    .ar          (ar_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] obs,
                     input logic [12:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Output words computed straight from the scaling rules.
  function automatic void model(
    input int n, input int w,
    input logic [11:0] ax, input logic [11:0] ay,
    input logic [11:0] wd, input logic [11:0] ht,
    input logic [1:0] sc,
    output logic [12:0] ox, output logic [12:0] oy, output int lat);
    int  vq, oh, wa, hq, ow;
    bit  m2;
    m2 = HEN && (sc == 2'd2);
    ox = {1'b0, ax};
    oy = {1'b0, ay};
    if (sc == 2'd0) begin
      lat = 1;
      return;
    end
    if (n == 0 || ay == 0 || ax[11] || ay[11] ||
        int'(ht) / n == 0 || (m2 && w == 0)) begin
      lat = 2;
      return;
    end
    vq = int'(ht) / n;
    oh = vq * n;
    wa = oh * int'(ax) / int'(ay);
    if (wa > int'(wd)) wa = int'(wd);
    oy = {1'b1, 12'(oh)};
    if (m2) begin
      hq = wa / w;
      if (hq == 0) hq = 1;
      ow = hq * w;
      if (ow > int'(wd)) ow = int'(wd);
      ox  = {1'b1, 12'(ow)};
      lat = 82;
    end else begin
      ox  = {1'b1, 12'(wa)};
      lat = 55;
    end
  endfunction

  task automatic pix(input logic d, input bit rce);
    int k;
    if (rce) begin
      k = $urandom_range(0, 1);
      repeat (k) begin
        ce = 1'b0;
        de = d;
        step();
      end
    end
    ce = 1'b1;
    de = d;
    step();
  endtask

  task automatic frame(input int n, input int wlast, input bit rce);
    for (int l = 0; l < n; l++) begin
      int wl;
      wl = (l == n - 1) ? wlast : (rce ? $urandom_range(1, 4) : 1);
      repeat (wl) pix(1'b1, rce);
      pix(1'b0, rce);
    end
    if (n > 0) last_w = wlast;
  endtask

  task automatic vs_evt();
    ce = 1'b1;
    de = 1'b0;
    vs = 1'b1;
    step();
    vs = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int n,
                           input int wl, input bit rce);
    frame(n, wl, rce);
    model(n, last_w, arx, ary, hw, hh, scale, exp_x, exp_y, exp_lat);
    vs_evt();
    if (exp_lat == 1) begin
      chk({tag, "_px"}, ar_if.VIDEO_ARX, exp_x);
      chk({tag, "_py"}, ar_if.VIDEO_ARY, exp_y);
      chk({tag, "_pbusy"}, {12'b0, ar_if.BUSY}, 13'd0);
    end else begin
      chk({tag, "_busy1"}, {12'b0, ar_if.BUSY}, 13'd1);
      repeat (exp_lat - 2) step();
      chk({tag, "_holdx"}, ar_if.VIDEO_ARX, cur_x);
      chk({tag, "_busyl"}, {12'b0, ar_if.BUSY}, 13'd1);
      step();
      chk({tag, "_x"}, ar_if.VIDEO_ARX, exp_x);
      chk({tag, "_y"}, ar_if.VIDEO_ARY, exp_y);
      chk({tag, "_busy0"}, {12'b0, ar_if.BUSY}, 13'd0);
    end
    cur_x = exp_x;
    cur_y = exp_y;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; vs = 1'b0; de = 1'b0;
    scale = 2'd0; arx = 12'd4; ary = 12'd3;
    hw = 12'd1920; hh = 12'd1080;
    repeat (3) step();
    chk("rst_x", ar_if.VIDEO_ARX, 13'd0);
    chk("rst_y", ar_if.VIDEO_ARY, 13'd0);
    chk("rst_busy", {12'b0, ar_if.BUSY}, 13'd0);

    rst = 1'b0;
    step();
    chk("pass_x", ar_if.VIDEO_ARX, {1'b0, arx});
    chk("pass_y", ar_if.VIDEO_ARY, {1'b0, ary});
    chk("pass_busy", {12'b0, ar_if.BUSY}, 13'd0);
    cur_x = {1'b0, arx};
    cur_y = {1'b0, ary};

    scale = 2'd1;
    run_frame("vert", 224, 256, 1'b0);
    scale = 2'd2;
    run_frame("both", 224, 256, 1'b0);

    scale = 2'd1; hw = 12'd1280; hh = 12'd720;
    arx = 12'd21; ary = 12'd9;
    run_frame("clip", 240, 1, 1'b0);

    arx = 12'd5; ary = 12'd4;
    run_frame("vq0", 800, 1, 1'b0);
    arx = 12'd7; ary = 12'd6;
    run_frame("node", 0, 1, 1'b0);

    // abort: a second frame event lands mid-computation at cycle 30
    hw = 12'd1920; hh = 12'd1080; arx = 12'd4; ary = 12'd3;
    frame(100, 1, 1'b0);
    vs_evt();
    for (int c = 1; c < 30; c++) begin
      ce = 1'b1;
      de = (c >= 2 && c <= 20 && (c % 2) == 0);
      step();
    end
    last_w = 1;
    model(10, 1, arx, ary, hw, hh, scale, exp_x, exp_y, exp_lat);
    vs_evt();
    chk("abort_busy1", {12'b0, ar_if.BUSY}, 13'd1);
    repeat (exp_lat - 2) step();
    chk("abort_holdx", ar_if.VIDEO_ARX, cur_x);
    chk("abort_holdy", ar_if.VIDEO_ARY, cur_y);
    step();
    chk("abort_x", ar_if.VIDEO_ARX, exp_x);
    chk("abort_y", ar_if.VIDEO_ARY, exp_y);
    cur_x = exp_x;
    cur_y = exp_y;

    frame(50, 1, 1'b0);
    vs_evt();
    repeat (39) step();
    rst = 1'b1;
    step();
    chk("mrst_x", ar_if.VIDEO_ARX, 13'd0);
    chk("mrst_y", ar_if.VIDEO_ARY, 13'd0);
    chk("mrst_busy", {12'b0, ar_if.BUSY}, 13'd0);
    rst = 1'b0;
    repeat (30) step();
    chk("mrst_hold", ar_if.VIDEO_ARX, 13'd0);
    chk("mrst_busy2", {12'b0, ar_if.BUSY}, 13'd0);
    cur_x = '0;
    cur_y = '0;
    last_w = 0;

    for (int i = 0; i < 12; i++) begin
      int n, wl;
      scale = 2'($urandom_range(0, 3));
      arx   = 12'($urandom_range(1, 40));
      ary   = 12'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) arx[11] = 1'b1;
      hw    = 12'($urandom_range(1, 600));
      hh    = 12'($urandom_range(0, 300));
      n     = $urandom_range(0, 40);
      wl    = $urandom_range(1, 30);
      run_frame("rnd", n, wl, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_scale_int.md
# video_scale_int

Integer-scaling aspect calculator placed directly downstream of the vertical crop stage. It measures the active frame size from the cropped DE, then computes integer output dimensions for the scaler. The vertical size is an integer multiple of the active lines. The width follows the incoming aspect ratio and is optionally snapped to an integer multiple of the active width. Results are emitted as absolute-size aspect words (bit 12 set) to the scaler's ARX/ARY inputs; in pass-through they carry the ratio unchanged.

## Interface
Parameters: none.

Ports:
- CLK_VIDEO  in  1  video clock; the only clock.
- RESET  in  1  reset, synchronous, active-high.
- CE_PIXEL  in  1  pixel enable; qualifies VGA_VS/VGA_DE sampling.
- VGA_VS  in  1  vertical sync, active-high.
- VGA_DE  in  1  cropped display enable from the crop stage.
- ARX, ARY  in  12  aspect ratio or absolute size from the crop stage.
- HDMI_WIDTH, HDMI_HEIGHT  in  12  output raster size.
- SCALE  in  2  0 = pass-through, 1 = integer vertical, 2 = integer both, 3 = same as 1.
- VIDEO_ARX, VIDEO_ARY  out  13  bit 12 = absolute size flag, [11:0] = value.
- BUSY  out  1  computation in progress.

## Operation
- Measurement, on CE_PIXEL only:
  - hcnt counts DE-high pixels and saturates at 4095. On the DE falling edge, hsize_run <= hcnt and hcnt <= 0.
  - vcnt counts DE falling edges and saturates at 4095.
- VS rising edge, CE-qualified, is the frame event:
  - vsize <= vcnt, hsize <= hsize_run, vcnt <= 0.
  - ARX, ARY, HDMI_*, SCALE are latched.
  - If SCALE != 0, the FSM starts.
- FSM states IDLE, DIV_V, MUL_V, DIV_A, DIV_H, DONE:
  - IDLE: waits for the frame event.
  - DIV_V: vq = HDMI_HEIGHT / vsize.
  - MUL_V: oheight = vq * vsize (12 bits).
  - DIV_A: wa = (oheight * ARX) / ARY, 24-bit dividend; wa is clipped to HDMI_WIDTH.
  - DIV_H (SCALE==2 only): hq = wa / hsize; if hq==0 then hq=1; owidth = min(hq*hsize, HDMI_WIDTH).
  - DONE: VIDEO_ARX <= {1,owidth or wa}, VIDEO_ARY <= {1,oheight}, then return to IDLE.
- Invalid cases produce pass-through for that frame: vsize==0, hsize==0 (mode 2), ARY==0, vq==0, or latched ARX[11]|ARY[11] set (input already absolute).
- Pass-through: VIDEO_ARX <= {0,ARX}, VIDEO_ARY <= {0,ARY}, registered every cycle while SCALE==0. For an invalid frame the values are written once, in DONE.
- A frame event during BUSY aborts the current computation and restarts it with the newly latched values. Outputs are not updated by an aborted computation.
- Outputs change only in DONE (both words in the same cycle) or in pass-through.

## Timing
- Reset values: VIDEO_ARX=0, VIDEO_ARY=0, BUSY=0, all counters and sizes 0, FSM=IDLE.
- Divider: start at cycle s, done pulse at s+25, quotient valid on the done cycle.
- Cycle 0 is the frame-event cycle:
  - DIV_V starts at cycle 1 and is done at 26; MUL_V at 27.
  - DIV_A starts at 28 and is done at 53.
  - Mode 1: DONE at 54, outputs visible at 55.
  - Mode 2: DIV_H starts at 55, done at 80, DONE at 81, outputs visible at 82.
- BUSY is high from cycle 1 through the DONE cycle inclusive.
- Invalid frame: DONE at cycle 1, outputs visible at 2.
- Pass-through latency: 1 cycle.
- RESET mid-operation forces the reset values on the next edge; there is no partial output.

## Configuration
- VIDEO_SCALE_INT_H_EN defined: DIV_H is present and SCALE==2 snaps the width to an integer multiple of hsize.
- Not defined: DIV_H and hsize tracking are removed; SCALE==2 behaves exactly as SCALE==1, with the same cycle counts.

## Structure
- Package video_scale_pkg:
  - FSM state enum.
  - SCALE mode constants.
  - Width constants: 12-bit size, 24-bit dividend, 13-bit output.
  - Divider latency constant (25).
- Sub-module video_div_seq: restoring divider with 24-bit dividend and 12-bit divisor; start/done handshake; ignores start while busy unless aborted via a synchronous clear.
- One divider instance, shared by DIV_V, DIV_A and DIV_H.

## Test plan
- Pass-through: SCALE=0, ARX=4, ARY=3 -> VIDEO_ARX=0x004, VIDEO_ARY=0x003 one cycle later; BUSY stays 0.
- Vertical integer: SCALE=1, 256x224 active, HDMI 1920x1080, 4:3 -> 55 cycles after the VS edge, VIDEO_ARY=0x1380 (896) and VIDEO_ARX=0x14AA (1194).
- Horizontal integer: same frame with SCALE=2 and the macro defined -> VIDEO_ARX=0x1400 (1024) at cycle 82. Without the macro -> 0x14AA at cycle 55.
- Clip: 240 lines, HDMI 1280x720, ARX=21, ARY=9, SCALE=1 -> VIDEO_ARY={1,720}, VIDEO_ARX={1,1280}.
- Invalid: 800 lines with HDMI_HEIGHT=720 (vq=0) -> {0,ARX}/{0,ARY} visible at cycle 2. No DE in the frame -> same result.
- Abort/reset: second VS edge at cycle 30 -> outputs appear 55 cycles after the second edge, computed from its sizes. RESET at cycle 40 -> outputs 0 and BUSY 0 on the next edge.
